// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared widths, constants and FSM encoding for fetch_ctrl
package fetch_ctrl_pkg;

   localparam int InstAddrBus = 32;
   localparam int InstBus     = 32;

   localparam logic                   RstEnable = 1'b0;
   localparam logic [InstAddrBus-1:0] ZeroAddr  = '0;
   localparam logic [InstBus-1:0]     NOP_INST  = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_REQ  = 2'd1,
      FETCH_WAIT = 2'd2,
      FETCH_HOLD = 2'd3
   } fetch_state_e;

   function automatic logic [InstAddrBus-1:0] pc_inc(input logic [InstAddrBus-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_ctrl_next_pc_sel.sv
// rtl/fetch_ctrl_next_pc_sel.sv - next-PC priority mux: trap, then redirect, then sequential +4
// FETCH_MISALIGN_CHK_EN keeps target bits [1:0]; otherwise they are forced to zero.
module next_pc_sel
   import fetch_ctrl_pkg::*;
(
   input  logic                   trap_valid_i,
   input  logic [InstAddrBus-1:0] trap_pc_i,
   input  logic                   redirect_valid_i,
   input  logic [InstAddrBus-1:0] redirect_pc_i,
   input  logic                   inc_en_i,
   input  logic [InstAddrBus-1:0] inc_base_i,
   input  logic [InstAddrBus-1:0] cur_pc_i,
   output logic                   redir_o,
   output logic [InstAddrBus-1:0] next_pc_o
);

   logic [InstAddrBus-1:0] target;

   always_comb begin
      target = trap_valid_i ? trap_pc_i : redirect_pc_i;
`ifndef FETCH_MISALIGN_CHK_EN
      target[1:0] = 2'b00;
`endif
      redir_o = trap_valid_i | redirect_valid_i;
      if (redir_o) begin
         next_pc_o = target;
      end else if (inc_en_i) begin
         next_pc_o = pc_inc(inc_base_i);
      end else begin
         next_pc_o = cur_pc_i;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC sequencing and single-outstanding imem fetch handshake
// FETCH_MISALIGN_CHK_EN adds if_misalign and parks on misaligned redirect targets.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [InstAddrBus-1:0] RESET_PC = ZeroAddr,
   parameter logic [InstBus-1:0]     NOP_INST = fetch_ctrl_pkg::NOP_INST
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   trap_valid,
   input  logic [InstAddrBus-1:0] trap_pc,
   input  logic                   redirect_valid,
   input  logic [InstAddrBus-1:0] redirect_pc,
   input  logic                   stall,
   output logic                   imem_req,
   output logic [InstAddrBus-1:0] imem_addr,
   input  logic                   imem_gnt,
   input  logic                   imem_rvalid,
   input  logic [InstBus-1:0]     imem_rdata,
   output logic                   if_valid,
   output logic [InstAddrBus-1:0] if_pc,
   output logic [InstBus-1:0]     if_inst,
`ifdef FETCH_MISALIGN_CHK_EN
   output logic                   if_misalign,
`endif
   input  logic                   if_ready
);

   fetch_state_e           state_q;
   logic [InstAddrBus-1:0] next_pc_q;
   logic [InstAddrBus-1:0] next_pc_d;
   logic                   kill_q;
   logic                   req_q;
   logic [InstAddrBus-1:0] addr_q;
   logic                   vld_q;
   logic [InstAddrBus-1:0] pc_q;
   logic [InstBus-1:0]     inst_q;
   logic                   redir;
   logic                   inc_en;
`ifdef FETCH_MISALIGN_CHK_EN
   logic                   misalign_q;
`endif

   // A redirect seen earlier in REQ (kill_q) must not be overwritten by the grant's +4.
   assign inc_en = (state_q == FETCH_REQ) && imem_gnt && !kill_q;

   next_pc_sel u_next_pc_sel (
      .trap_valid_i     (trap_valid),
      .trap_pc_i        (trap_pc),
      .redirect_valid_i (redirect_valid),
      .redirect_pc_i    (redirect_pc),
      .inc_en_i         (inc_en),
      .inc_base_i       (addr_q),
      .cur_pc_i         (next_pc_q),
      .redir_o          (redir),
      .next_pc_o        (next_pc_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (rst_n == RstEnable) begin
         state_q   <= FETCH_IDLE;
         next_pc_q <= RESET_PC;
         kill_q    <= 1'b0;
         req_q     <= 1'b0;
         addr_q    <= RESET_PC;
         vld_q     <= 1'b0;
         pc_q      <= RESET_PC;
         inst_q    <= NOP_INST;
`ifdef FETCH_MISALIGN_CHK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         next_pc_q <= next_pc_d;
         case (state_q)
            FETCH_IDLE: begin
               if (!redir) begin
`ifdef FETCH_MISALIGN_CHK_EN
                  if (next_pc_q[1:0] != 2'b00) begin
                     vld_q      <= 1'b1;
                     inst_q     <= NOP_INST;
                     pc_q       <= next_pc_q;
                     misalign_q <= 1'b1;
                     state_q    <= FETCH_HOLD;
                  end else
`endif
                  if (!stall) begin
                     req_q   <= 1'b1;
                     addr_q  <= next_pc_q;
                     state_q <= FETCH_REQ;
                  end
               end
            end
            FETCH_REQ: begin
               kill_q <= kill_q | redir;
               if (imem_gnt) begin
                  req_q   <= 1'b0;
                  state_q <= FETCH_WAIT;
               end
            end
            FETCH_WAIT: begin
               if (imem_rvalid) begin
                  if (kill_q || redir) begin
                     kill_q  <= 1'b0;
                     state_q <= FETCH_IDLE;
                  end else begin
                     vld_q   <= 1'b1;
                     inst_q  <= imem_rdata;
                     pc_q    <= addr_q;
                     state_q <= FETCH_HOLD;
                  end
               end else if (redir) begin
                  kill_q <= 1'b1;
               end
            end
            FETCH_HOLD: begin
`ifdef FETCH_MISALIGN_CHK_EN
               if (misalign_q) begin
                  if (trap_valid) begin
                     vld_q      <= 1'b0;
                     misalign_q <= 1'b0;
                     state_q    <= FETCH_IDLE;
                  end
               end else
`endif
               if (redir || if_ready) begin
                  vld_q   <= 1'b0;
                  inst_q  <= NOP_INST;
                  state_q <= FETCH_IDLE;
               end
            end
            default: state_q <= FETCH_IDLE;
         endcase
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign if_valid  = vld_q;
   assign if_pc     = pc_q;
   assign if_inst   = inst_q;
`ifdef FETCH_MISALIGN_CHK_EN
   assign if_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl against an expected-PC sequence model
module tb_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        trap_valid = 1'b0, redirect_valid = 1'b0, stall = 1'b0;
   logic        imem_gnt = 1'b0, imem_rvalid = 1'b0, if_ready = 1'b0;
   logic [31:0] trap_pc = '0, redirect_pc = '0, imem_rdata = '0;
   logic        imem_req, if_valid;
   logic [31:0] imem_addr, if_pc, if_inst;
`ifdef FETCH_MISALIGN_CHK_EN
   logic        if_misalign;
`endif

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic [31:0] exp_pc = RST_PC;
   logic [31:0] salt = '0;

   fetch_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .trap_valid     (trap_valid),
      .trap_pc        (trap_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_inst        (if_inst),
`ifdef FETCH_MISALIGN_CHK_EN
      .if_misalign    (if_misalign),
`endif
      .if_ready       (if_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ salt;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (imem_req !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk1("req_seen", imem_req, 1'b1);
      chk("fetch_addr", imem_addr, exp_pc);
   endtask

   task automatic issue(input int gnt_dly);
      logic [31:0] a;
      wait_req();
      a = imem_addr;
      for (int i = 0; i < gnt_dly; i++) begin
         tick();
         chk("addr_hold", imem_addr, a);
         chk1("req_hold", imem_req, 1'b1);
      end
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      chk1("req_drop", imem_req, 1'b0);
   endtask

   task automatic respond(input int rv_dly, input logic [31:0] a);
      repeat (rv_dly) tick();
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(a);
      tick();
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
   endtask

   task automatic check_deliver();
      chk1("if_valid", if_valid, 1'b1);
      chk("if_pc", if_pc, exp_pc);
      chk("if_inst", if_inst, mem_word(exp_pc));
   endtask

   task automatic accept(input int rdy_dly);
      for (int i = 0; i < rdy_dly; i++) begin
         tick();
         chk1("hold_valid", if_valid, 1'b1);
         chk("hold_pc", if_pc, exp_pc);
         chk("hold_inst", if_inst, mem_word(exp_pc));
         chk1("hold_no_req", imem_req, 1'b0);
      end
      if_ready = 1'b1;
      tick();
      if_ready = 1'b0;
      chk1("drop_valid", if_valid, 1'b0);
      chk("drop_inst", if_inst, NOP);
      exp_pc = exp_pc + 32'd4;
   endtask

   task automatic fetch_one(input int g, input int r, input int d);
      issue(g);
      respond(r, exp_pc);
      check_deliver();
      accept(d);
   endtask

   initial begin
      int          c0;
      int          mode;
      logic        use_trap;
      logic [31:0] tgt, tgt2, old;

      salt = $urandom;
      repeat (2) tick();
      chk1("rst_req", imem_req, 1'b0);
      chk("rst_addr", imem_addr, RST_PC);
      chk1("rst_valid", if_valid, 1'b0);
      chk("rst_pc", if_pc, RST_PC);
      chk("rst_inst", if_inst, NOP);

      // release, first fetch latency and sequential 0x0, 0x4
      rst_n = 1'b1;
      c0 = cyc;
      issue(0);
      respond(0, exp_pc);
      chk("first_latency", cyc - c0, 32'd3);
      check_deliver();
      accept(0);
      fetch_one(0, 0, 0);

      // redirect while waiting for 0x8
      issue(0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      tick();
      redirect_valid = 1'b0;
      respond(1, 32'h8);
      chk1("wait_kill_valid", if_valid, 1'b0);
      exp_pc = 32'h100;
      fetch_one(0, 0, 0);
      fetch_one(1, 1, 1);

      // redirect in the same cycle as rvalid
      issue(0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h180;
      imem_rvalid    = 1'b1;
      imem_rdata     = mem_word(32'h108);
      tick();
      redirect_valid = 1'b0;
      imem_rvalid    = 1'b0;
      chk1("rvalid_kill_valid", if_valid, 1'b0);
      exp_pc = 32'h180;

      // redirect during REQ before the grant
      wait_req();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      tick();
      redirect_valid = 1'b0;
      chk("req_addr_kept", imem_addr, 32'h180);
      chk1("req_kept", imem_req, 1'b1);
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      respond(0, 32'h180);
      chk1("req_kill_valid", if_valid, 1'b0);
      exp_pc = 32'h300;

      // trap and redirect together while holding an instruction
      issue(0);
      respond(0, exp_pc);
      check_deliver();
      trap_valid     = 1'b1;
      trap_pc        = 32'h200;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      if_ready       = 1'b1;
      tick();
      trap_valid     = 1'b0;
      redirect_valid = 1'b0;
      if_ready       = 1'b0;
      chk1("squash_valid", if_valid, 1'b0);
      exp_pc = 32'h200;
      fetch_one(0, 0, 0);

      // decode backpressure for 5 cycles, then resume one cycle after acceptance
      issue(0);
      respond(0, exp_pc);
      check_deliver();
      accept(5);
      tick();
      chk1("resume_req", imem_req, 1'b1);
      chk("resume_addr", imem_addr, exp_pc);
      fetch_one(0, 0, 0);

      // wrap at the top of the address space, with stall and a slow grant
      issue(0);
      respond(0, exp_pc);
      check_deliver();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      chk1("wrap_squash", if_valid, 1'b0);
      exp_pc = 32'hFFFF_FFFC;
      issue(4);
      respond(0, exp_pc);
      check_deliver();
      stall = 1'b1;
      accept(0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk1("stall_no_req", imem_req, 1'b0);
      end
      stall = 1'b0;
      chk("wrap_exp", exp_pc, 32'h0);
      fetch_one(0, 0, 0);

      // asynchronous reset in WAIT, late rvalid after release
      issue(0);
      rst_n = 1'b0;
      #1;
      chk1("mid_rst_req", imem_req, 1'b0);
      chk("mid_rst_addr", imem_addr, RST_PC);
      chk1("mid_rst_valid", if_valid, 1'b0);
      chk("mid_rst_inst", if_inst, NOP);
      tick();
      tick();
      rst_n       = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      tick();
      imem_rvalid = 1'b0;
      chk1("late_rvalid_ignored", if_valid, 1'b0);
      exp_pc = RST_PC;
      fetch_one(0, 0, 0);

      // randomized fetch/redirect mix
      for (int k = 0; k < 12; k++) begin
         mode     = $urandom_range(0, 3);
         use_trap = 1'($urandom_range(0, 1));
         tgt      = $urandom;
         tgt2     = $urandom;
`ifdef FETCH_MISALIGN_CHK_EN
         tgt[1:0]  = 2'b00;
         tgt2[1:0] = 2'b00;
`endif
         if (mode < 2) begin
            fetch_one($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3));
         end else begin
            if (mode == 2) begin
               issue($urandom_range(0, 2));
               old = exp_pc;
            end else begin
               wait_req();
               old = exp_pc;
               imem_gnt = 1'b1;
            end
            redirect_valid = 1'b1;
            redirect_pc    = tgt;
            trap_valid     = use_trap;
            trap_pc        = tgt2;
            tick();
            imem_gnt       = 1'b0;
            redirect_valid = 1'b0;
            trap_valid     = 1'b0;
            respond($urandom_range(0, 2), old);
            chk1("rnd_kill_valid", if_valid, 1'b0);
            exp_pc = use_trap ? {tgt2[31:2], 2'b00} : {tgt[31:2], 2'b00};
         end
      end
      fetch_one(0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the program counter and the instruction-memory fetch handshake for the single-issue RISC-V core.
- Selects next PC by priority: trap, then branch/jump redirect, then sequential +4.
- Keeps one fetch outstanding, drops results made stale by a redirect, and presents instructions to decode with valid/ready.
- Sits between the EX-stage branch resolution and the imem port, as the controlling wrapper around the PC register.

Parameters:
- RESET_PC, 32'h0000_0000, PC issued on the first fetch after reset.
- NOP_INST, 32'h0000_0013, value driven on if_inst when not valid (addi x0,x0,0).

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset; asserting it clears state immediately, and it is released synchronously by the reset tree.
- trap_valid  in  1  trap/exception redirect request, highest priority.
- trap_pc  in  32  trap vector target.
- redirect_valid  in  1  taken branch/jump from EX (branch & ALU_zero, or jal/jalr).
- redirect_pc  in  32  branch/jump target (PC+imm already summed in EX).
- stall  in  1  hazard stall; blocks issue of new fetches.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; held stable while imem_req=1 and imem_gnt=0.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid; at most one per granted request, ≥1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  instruction valid to decode.
- if_pc  out  32  PC of if_inst.
- if_inst  out  32  fetched instruction.
- if_ready  in  1  decode accepts when if_valid & if_ready.

Behaviour:
- Reset values:
  - imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=RESET_PC, if_inst=NOP_INST.
  - state=IDLE, next_pc=RESET_PC, kill=0.
- States:
  - IDLE: if !stall, assert imem_req with imem_addr=next_pc, go REQ.
  - REQ: on imem_gnt, set next_pc=imem_addr+4 and go WAIT. Otherwise hold the address.
  - WAIT: on imem_rvalid:
    - kill=1: discard data, clear kill, go IDLE.
    - kill=0: register if_inst=imem_rdata, if_pc=fetch addr, if_valid=1, go HOLD.
  - HOLD: on if_valid & if_ready, drop if_valid and go IDLE.
- Throughput and latency:
  - Minimum latency from IDLE to if_valid is 3 cycles (req, gnt-same-cycle, rvalid next, register).
  - Non-pipelined: one fetch in flight.
- Redirect handling (trap_valid overrides redirect_valid when both are high in the same cycle):
  - next_pc := target.
  - IDLE: next_pc=target, then normal IDLE behaviour next cycle.
  - REQ: imem_addr is not changed (protocol). The pending fetch is marked kill=1 when granted; if gnt occurs the same cycle, kill=1 is set.
  - WAIT: kill=1. This also applies if rvalid arrives the same cycle as the redirect: the data is discarded and if_valid stays 0.
  - HOLD: if_valid cleared next cycle even if if_ready=1 the same cycle (the instruction is squashed), go IDLE.
  - next_pc+4 after a redirect is suppressed: the target overrides the increment from a same-cycle gnt.
- stall:
  - Only gates IDLE→REQ.
  - Requests already issued complete.
  - if_valid held while if_ready=0.
- Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 → 0).
- Mid-operation reset: all outputs return to reset values asynchronously. Any late imem_rvalid after reset release is ignored, because state is IDLE.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- With the macro defined:
  - Adds output if_misalign (1). It is set with if_valid (if_inst=NOP_INST) when a redirect target has [1:0]≠0.
  - No imem request is issued for that target.
  - Controller waits in HOLD for trap_valid.
- Without the macro: target bits [1:0] are forced to 0 and no port is added.

Decomposition:
- Shared package/define file:
  - InstAddrBus, InstBus widths, RstEnable, ZeroAddr, NOP_INST.
  - State encoding constants FETCH_IDLE/REQ/WAIT/HOLD.
- Sub-module next_pc_sel: combinational priority mux (trap > redirect > +4) feeding next_pc.
- The FSM and handshake stay in fetch_ctrl.

Test Plan:
- Reset release, imem gnt same cycle, rvalid +1 → fetches at 0x0, 0x4, 0x8; if_inst matches memory; if_valid first high 3 cycles after release.
- redirect_valid=1, redirect_pc=0x100 while in WAIT for 0x8 → 0x8 data discarded (if_valid stays 0); next imem_addr=0x100, then 0x104.
- trap_valid (trap_pc=0x200) and redirect_valid (0x100) asserted in the same cycle → next fetch at 0x200.
- if_ready=0 for 5 cycles in HOLD → if_valid/if_pc/if_inst stable; no new imem_req; fetch resumes one cycle after acceptance.
- stall=1 in IDLE with gnt delayed 4 cycles on the prior request → no new imem_req during stall; imem_addr stable during REQ; next_pc=0xFFFF_FFFC → following fetch at 0x0.
- rst_n asserted in WAIT, memory returns rvalid after release → rvalid ignored, if_valid=0, first fetch at RESET_PC.
